// File: rtl/gate_vector_bist.sv
// rtl/gate_vector_bist.sv - exhaustive-vector BIST engine with MISR response compaction
//
// Sweeps every N_IN-bit vector once per run, folds the two DUT response bits
// into a MISR and compares the final signature against GOLDEN_SIG.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   one-cycle pulse; accepted only in IDLE or DONE
//   vec        out  DUT stimulus (bit5=a .. bit0=l)
//   vec_valid  out  vec carries a live test vector
//   resp_t     in   DUT output t (folded into MISR bit1)
//   resp_k     in   DUT output k (folded into MISR bit0)
//   busy       out  run or drain in progress
//   done       out  run complete; pass/signature valid and held
//   pass       out  final signature matched GOLDEN_SIG
//   signature  out  current MISR contents
module gate_vector_bist #(
    parameter int               N_IN       = 6,
    parameter int               SIG_W      = 16,
    parameter logic [SIG_W-1:0] POLY       = 16'h1021,
    parameter logic [SIG_W-1:0] SEED       = 16'h0000,
    parameter int               DUT_LAT    = 0,
    parameter logic [SIG_W-1:0] GOLDEN_SIG = 16'h0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [N_IN-1:0]  vec,
    output logic             vec_valid,
    input  logic             resp_t,
    input  logic             resp_k,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    // run_cnt holds (vectors issued so far); it reaches 2^N_IN on the last vector,
    // hence the extra bit.
    localparam logic [N_IN:0] RUN_LEN    = {1'b1, {N_IN{1'b0}}};
    localparam int            DW         = (DUT_LAT < 2) ? 1 : $clog2(DUT_LAT);
    localparam logic [DW-1:0] DRAIN_LAST = DW'((DUT_LAT > 0) ? DUT_LAT - 1 : 0);

    state_t           state_q, state_d;
    logic [N_IN-1:0]  vec_q, vec_d;
    logic             vec_valid_q, vec_valid_d;
    logic [N_IN:0]    run_cnt_q, run_cnt_d;
    logic [DW-1:0]    drain_cnt_q, drain_cnt_d;
    logic [SIG_W-1:0] sig_q, sig_d;
    logic             pass_q, pass_d;
    logic [SIG_W-1:0] misr_next;
    logic             samp_en;
    logic             start_ok;

    // Sample enable tracks vec_valid through the DUT pipeline so each response
    // is folded in exactly when it belongs to a live vector.
    generate
        if (DUT_LAT == 0) begin : g_no_lat
            assign samp_en = vec_valid_q;
        end else begin : g_lat
            logic [DUT_LAT-1:0] vv_pipe_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    vv_pipe_q <= '0;
                end else begin
                    vv_pipe_q[0] <= vec_valid_q;
                    for (int i = 1; i < DUT_LAT; i++) begin
                        vv_pipe_q[i] <= vv_pipe_q[i-1];
                    end
                end
            end
            assign samp_en = vv_pipe_q[DUT_LAT-1];
        end
    endgenerate

    assign start_ok = start && ((state_q == S_IDLE) || (state_q == S_DONE));

    always_comb begin
        misr_next = {sig_q[SIG_W-2:0], 1'b0};
        if (sig_q[SIG_W-1]) begin
            misr_next = misr_next ^ POLY;
        end
        misr_next[1:0] = misr_next[1:0] ^ {resp_t, resp_k};
    end

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            vec_q       <= '0;
            vec_valid_q <= 1'b0;
            run_cnt_q   <= '0;
            drain_cnt_q <= '0;
            sig_q       <= SEED;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            vec_valid_q <= vec_valid_d;
            run_cnt_q   <= run_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            sig_q       <= sig_d;
            pass_q      <= pass_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) state_d = S_RUN;
            end
            S_RUN: begin
                if (run_cnt_q == RUN_LEN) state_d = (DUT_LAT == 0) ? S_DONE : S_DRAIN;
            end
            S_DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        vec_d       = vec_q;
        vec_valid_d = vec_valid_q;
        run_cnt_d   = run_cnt_q;
        drain_cnt_d = drain_cnt_q;
        sig_d       = sig_q;
        pass_d      = pass_q;
        if (samp_en) begin
            sig_d = misr_next;
        end
        if (start_ok) begin
            vec_d       = '0;
            vec_valid_d = 1'b1;
            run_cnt_d   = (N_IN+1)'(1);
            drain_cnt_d = '0;
            sig_d       = SEED;
            pass_d      = 1'b0;
        end else if (state_q == S_RUN) begin
            // vec wraps to 0 on the same edge that ends the run
            vec_d     = vec_q + N_IN'(1);
            run_cnt_d = run_cnt_q + (N_IN+1)'(1);
            if (run_cnt_q == RUN_LEN) vec_valid_d = 1'b0;
        end else if (state_q == S_DRAIN) begin
            drain_cnt_d = drain_cnt_q + DW'(1);
        end
        // The final MISR update lands on the same edge that enters DONE.
        if ((state_q != S_DONE) && (state_d == S_DONE)) begin
            pass_d = (sig_d == GOLDEN_SIG);
        end
    end

    // Outputs
    always_comb begin
        busy = (state_q == S_RUN) || (state_q == S_DRAIN);
        done = (state_q == S_DONE);
    end

    assign vec       = vec_q;
    assign vec_valid = vec_valid_q;
    assign pass      = pass_q;
    assign signature = sig_q;

endmodule

// File: tb/tb_gate_vector_bist.sv
// tb/tb_gate_vector_bist.sv - scoreboard bench for gate_vector_bist
module tb_gate_vector_bist;
    localparam logic [15:0] POLY = 16'h1021;
    localparam logic [15:0] SEED = 16'h0000;

    function automatic logic [15:0] step(input logic [15:0] s, input logic t, input logic k);
        logic [15:0] n;
        n = s << 1;
        if (s[15]) n = n ^ POLY;
        n = n ^ {14'd0, t, k};
        return n;
    endfunction

    // Gate block t=a&b, k=c|d over all 64 vectors
    function automatic logic [15:0] gate_model();
        logic [15:0] s;
        logic [5:0]  v;
        s = SEED;
        for (int i = 0; i < 64; i++) begin
            v = 6'(i);
            s = step(s, v[5] & v[4], v[3] | v[2]);
        end
        return s;
    endfunction

    localparam logic [15:0] GOLD2 = gate_model();

    typedef struct {
        logic [15:0] sig;
        logic        pass;
        int          dcyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic start_a, start_b;
    logic [5:0] vec_a, vec_b;
    logic vv_a, vv_b, t_a, k_a, t_b, k_b;
    logic busy_a, busy_b, done_a, done_b, pass_a, pass_b;
    logic [15:0] sig_a, sig_b;
    logic [1:0] p1, p2;

    int mode;
    logic tbl_t [64];
    logic tbl_k [64];
    int cyc = 0;
    int s_cyc = 0;
    int total = 0;
    int bad = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb, ex;
    logic done_a_prev = 1'b0;
    logic done_b_prev = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        t_a = 1'b0;
        k_a = 1'b0;
        case (mode)
            0: begin t_a = 1'b0; k_a = 1'b0; end
            1: begin t_a = 1'b1; k_a = 1'b0; end
            default: begin t_a = tbl_t[vec_a]; k_a = tbl_k[vec_a]; end
        endcase
    end

    always @(posedge clk) begin
        p1 <= {vec_b[5] & vec_b[4], vec_b[3] | vec_b[2]};
        p2 <= p1;
    end
    assign t_b = p2[1];
    assign k_b = p2[0];

    gate_vector_bist #(
        .N_IN(6), .SIG_W(16), .POLY(POLY), .SEED(SEED), .DUT_LAT(0), .GOLDEN_SIG(16'h0000)
    ) u_a (
        .clk(clk), .rst(rst), .start(start_a), .vec(vec_a), .vec_valid(vv_a),
        .resp_t(t_a), .resp_k(k_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .signature(sig_a)
    );

    gate_vector_bist #(
        .N_IN(6), .SIG_W(16), .POLY(POLY), .SEED(SEED), .DUT_LAT(2), .GOLDEN_SIG(GOLD2)
    ) u_b (
        .clk(clk), .rst(rst), .start(start_b), .vec(vec_b), .vec_valid(vv_b),
        .resp_t(t_b), .resp_k(k_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .signature(sig_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] model_a(input int m);
        logic [15:0] s;
        s = SEED;
        for (int i = 0; i < 64; i++) begin
            case (m)
                0: s = step(s, 1'b0, 1'b0);
                1: s = step(s, 1'b1, 1'b0);
                default: s = step(s, tbl_t[i], tbl_k[i]);
            endcase
        end
        return s;
    endfunction

    task automatic new_tables();
        for (int i = 0; i < 64; i++) begin
            tbl_t[i] = 1'($urandom_range(0, 1));
            tbl_k[i] = 1'($urandom_range(0, 1));
        end
    endtask

    // Issue start to A at the next edge; returns at the negedge after edge S.
    task automatic start_a_run();
        exp_t e;
        e.sig  = model_a(mode);
        e.pass = (e.sig == 16'h0000);
        @(negedge clk);
        s_cyc  = cyc + 1;
        e.dcyc = cyc + 1 + 64;
        qa.push_back(e);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic wait_a_done();
        int n;
        n = 0;
        while (!done_a && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("a_done_reached", done_a, 1);
        @(negedge clk);
    endtask

    // Monitor A: vector sequence and end-of-run scoreboard
    always @(negedge clk) begin
        if (!rst && vv_a) begin
            chk("a_vec_seq", vec_a, 32'(cyc - s_cyc));
        end
        if (done_a && !done_a_prev) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_done", 1, 0);
            end else begin
                ea = qa.pop_front();
                chk("a_done_cycle", cyc, ea.dcyc);
                chk("a_signature", sig_a, ea.sig);
                chk("a_pass", pass_a, ea.pass);
                chk("a_busy_in_done", busy_a, 0);
            end
        end
        done_a_prev <= done_a;
    end

    // Monitor B: DUT_LAT=2 instance
    always @(negedge clk) begin
        if (done_b && !done_b_prev) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_done", 1, 0);
            end else begin
                eb = qb.pop_front();
                chk("b_done_cycle", cyc, eb.dcyc);
                chk("b_signature", sig_b, eb.sig);
                chk("b_pass", pass_b, eb.pass);
            end
        end
        done_b_prev <= done_b;
    end

    initial begin
        int n;
        rst = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        mode = 0;
        new_tables();
        repeat (3) @(negedge clk);
        chk("rst_vec", vec_a, 0);
        chk("rst_vec_valid", vv_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_pass", pass_a, 0);
        chk("rst_sig", sig_a, SEED);
        // start together with rst: rst wins
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        chk("rst_beats_start", busy_a, 0);
        rst = 1'b0;
        @(negedge clk);

        // all-zero responses
        mode = 0;
        start_a_run();
        chk("start_busy", busy_a, 1);
        wait_a_done();

        // constant t=1
        mode = 1;
        start_a_run();
        chk("restart_done_drop", done_a, 0);
        chk("restart_sig_seed", sig_a, SEED);
        @(negedge clk);
        chk("t1_first_sample", sig_a, 16'h0002);
        @(negedge clk);
        chk("t1_second_sample", sig_a, 16'h0006);
        wait_a_done();

        // random truth tables, each run twice back to back from DONE
        mode = 2;
        for (int r = 0; r < 3; r++) begin
            new_tables();
            start_a_run();
            wait_a_done();
            start_a_run();
            chk("rerun_done_drop", done_a, 0);
            chk("rerun_sig_seed", sig_a, SEED);
            wait_a_done();
        end

        // start while busy is ignored
        new_tables();
        start_a_run();
        repeat (9) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_a_done();

        // rst mid-run, then a clean run
        start_a_run();
        repeat (19) @(negedge clk);
        rst = 1'b1;
        ex = qa.pop_back();
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_vec", vec_a, 0);
        chk("midrst_vec_valid", vv_a, 0);
        chk("midrst_busy", busy_a, 0);
        chk("midrst_sig", sig_a, SEED);
        repeat (3) @(negedge clk);
        chk("midrst_no_done", done_a, 0);
        start_a_run();
        wait_a_done();

        // pipelined gate block on instance B
        @(negedge clk);
        ex.sig  = GOLD2;
        ex.pass = 1'b1;
        ex.dcyc = cyc + 1 + 66;
        qb.push_back(ex);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        n = 0;
        while (!done_b && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("b_done_reached", done_b, 1);
        @(negedge clk);

        chk("a_queue_empty", qa.size(), 0);
        chk("b_queue_empty", qb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
